csr_file: RTL

Machine-mode control and status register file for each core. Sits directly downstream of the decode-stage CSR control logic: consumes its read/write/set/clear enables, the CSR address, and the ALU-passed operand. Returns the old CSR value for the writeback of `rd`. Also maintains the cycle/instret counters and captures trap state for the fetch/redirect logic.

---
 rtl/csr_file.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
//
// Machine-mode CSR file for one hart. Sits behind the decode-stage CSR control
// logic: takes its read/write/set/clear enables, the 12-bit CSR number and the
// ALU-forwarded operand, and returns the pre-update CSR value for the rd
// writeback. Also captures trap state and exposes mtvec/mepc/MIE to the
// fetch/redirect logic.
//
// Configuration macro:
//   CSR_PERF_COUNTERS_EN - when defined, the 64-bit mcycle/minstret counters
//                          and their user-mode read-only shadows exist. When
//                          undefined those eight addresses decode as
//                          unimplemented and retire is ignored.
//
// Parameters:
//   CORE            - hart index returned by mhartid
//   MTVEC_RESET     - reset value of mtvec
//   SCAN_CYCLES_MIN - first cycle of the scan debug print window
//   SCAN_CYCLES_MAX - last cycle of the scan debug print window
//
// Ports:
//   clock, reset        - single clock, synchronous active-high reset
//   CSR_read_en         - read access; read_data valid this cycle
//   CSR_write_en        - CSRRW/CSRRWI, new = write_data
//   CSR_set_en          - CSRRS/CSRRSI, new = old | write_data
//   CSR_clear_en        - CSRRC/CSRRCI, new = old & ~write_data
//   CSR_address         - CSR number (instruction bits 31:20)
//   write_data          - operand (rs1 or zero-extended uimm)
//   retire              - one instruction retired this cycle
//   trap_valid          - trap taken this cycle
//   trap_pc/cause/value - trap capture payload
//   mret                - MRET executing this cycle
//   read_data           - combinational old value of the addressed CSR
//   illegal_csr         - combinational illegal-access flag
//   mtvec_out, mepc_out - current trap vector / exception PC
//   global_ie           - mstatus.MIE
//   scan                - debug print enable (no hardware behind it in the
//                         synthesizable view; the print lives in simulation
//                         models only)
// -----------------------------------------------------------------------------
module csr_file #(
    parameter int unsigned CORE            = 0,
    parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
    parameter int unsigned SCAN_CYCLES_MIN = 0,
    parameter int unsigned SCAN_CYCLES_MAX = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        CSR_read_en,
    input  logic        CSR_write_en,
    input  logic        CSR_set_en,
    input  logic        CSR_clear_en,
    input  logic [11:0] CSR_address,
    input  logic [31:0] write_data,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_value,
    input  logic        mret,
    output logic [31:0] read_data,
    output logic        illegal_csr,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        global_ie,
    input  logic        scan
);

    // CSR numbers
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
`ifdef CSR_PERF_COUNTERS_EN
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

    // Writable-bit masks; bits outside a mask are hard-wired to zero
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

    localparam logic [31:0] HART_ID = 32'(CORE);

    // New value produced by a software access; write beats set beats clear
    function automatic logic [31:0] csr_op(
        input logic        wr,
        input logic        st,
        input logic [31:0] old,
        input logic [31:0] operand
    );
        if (wr) begin
            return operand;
        end else if (st) begin
            return old | operand;
        end else begin
            return old & ~operand;
        end
    endfunction

    // Architectural state
    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;

    // Access decode
    logic        sw_any;
    logic        csr_any;
    logic        addr_impl;
    logic        sw_apply;
    logic [31:0] csr_old;
    logic [31:0] sw_value;
    logic [31:0] mstatus_value;

    logic we_mstatus;
    logic we_mie;
    logic we_mtvec;
    logic we_mscratch;
    logic we_mepc;
    logic we_mcause;
    logic we_mtval;

    assign mstatus_value = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};

`ifdef CSR_PERF_COUNTERS_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
    logic [63:0] mcycle_inc;
    logic [63:0] minstret_inc;
    logic [63:0] mcycle_next;
    logic [63:0] minstret_next;
    logic        we_mcycle;
    logic        we_mcycleh;
    logic        we_minstret;
    logic        we_minstreth;
`endif

    assign sw_any  = CSR_write_en | CSR_set_en | CSR_clear_en;
    assign csr_any = sw_any | CSR_read_en;

    // Old-value mux doubles as the implemented-address decoder
    always_comb begin
        addr_impl = 1'b1;
        csr_old   = 32'd0;
        case (CSR_address)
            ADDR_MSTATUS:  csr_old = mstatus_value;
            ADDR_MIE:      csr_old = mie_q;
            ADDR_MTVEC:    csr_old = mtvec_q;
            ADDR_MSCRATCH: csr_old = mscratch_q;
            ADDR_MEPC:     csr_old = mepc_q;
            ADDR_MCAUSE:   csr_old = mcause_q;
            ADDR_MTVAL:    csr_old = mtval_q;
            ADDR_MHARTID:  csr_old = HART_ID;
`ifdef CSR_PERF_COUNTERS_EN
            ADDR_MCYCLE,   ADDR_CYCLE:    csr_old = mcycle_q[31:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:   csr_old = mcycle_q[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  csr_old = minstret_q[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: csr_old = minstret_q[63:32];
`endif
            default:       addr_impl = 1'b0;
        endcase
    end

    // Address space 0xC00-0xFFF is read-only by encoding, so any modifying
    // enable there is illegal even when the register exists.
    assign illegal_csr = csr_any &
                         (~addr_impl | ((CSR_address[11:10] == 2'b11) & sw_any));

    assign read_data = (CSR_read_en & addr_impl) ? csr_old : 32'd0;

    // Illegal accesses are squashed before they reach any register
    assign sw_apply = sw_any & ~illegal_csr;
    assign sw_value = csr_op(CSR_write_en, CSR_set_en, csr_old, write_data);

    assign we_mstatus  = sw_apply & (CSR_address == ADDR_MSTATUS);
    assign we_mie      = sw_apply & (CSR_address == ADDR_MIE);
    assign we_mtvec    = sw_apply & (CSR_address == ADDR_MTVEC);
    assign we_mscratch = sw_apply & (CSR_address == ADDR_MSCRATCH);
    assign we_mepc     = sw_apply & (CSR_address == ADDR_MEPC);
    assign we_mcause   = sw_apply & (CSR_address == ADDR_MCAUSE);
    assign we_mtval    = sw_apply & (CSR_address == ADDR_MTVAL);

    // mstatus: trap outranks mret, which outranks a software write
    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else if (trap_valid) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (we_mstatus) begin
            mstatus_mie_q  <= sw_value[3];
            mstatus_mpie_q <= sw_value[7];
        end
    end

    // Registers never touched by trap or mret
    always_ff @(posedge clock) begin
        if (reset) begin
            mie_q      <= 32'd0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'd0;
        end else begin
            if (we_mie) begin
                mie_q <= sw_value & MIE_MASK;
            end
            if (we_mtvec) begin
                mtvec_q <= sw_value & MTVEC_MASK;
            end
            if (we_mscratch) begin
                mscratch_q <= sw_value;
            end
        end
    end

    // Trap capture registers; a same-cycle software write to these is dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
            mtval_q  <= 32'd0;
        end else if (trap_valid) begin
            mepc_q   <= trap_pc & MEPC_MASK;
            mcause_q <= trap_cause;
            mtval_q  <= trap_value;
        end else begin
            if (we_mepc) begin
                mepc_q <= sw_value & MEPC_MASK;
            end
            if (we_mcause) begin
                mcause_q <= sw_value;
            end
            if (we_mtval) begin
                mtval_q <= sw_value;
            end
        end
    end

`ifdef CSR_PERF_COUNTERS_EN
    assign we_mcycle    = sw_apply & (CSR_address == ADDR_MCYCLE);
    assign we_mcycleh   = sw_apply & (CSR_address == ADDR_MCYCLEH);
    assign we_minstret  = sw_apply & (CSR_address == ADDR_MINSTRET);
    assign we_minstreth = sw_apply & (CSR_address == ADDR_MINSTRETH);

    assign mcycle_inc   = mcycle_q + 64'd1;
    assign minstret_inc = minstret_q + {63'd0, retire};

    // A written half takes the operand verbatim; the other half still picks
    // up the carry of the increment computed on the old 64-bit value.
    always_comb begin
        mcycle_next   = mcycle_inc;
        minstret_next = minstret_inc;
        if (we_mcycle) begin
            mcycle_next[31:0] = sw_value;
        end
        if (we_mcycleh) begin
            mcycle_next[63:32] = sw_value;
        end
        if (we_minstret) begin
            minstret_next[31:0] = sw_value;
        end
        if (we_minstreth) begin
            minstret_next[63:32] = sw_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mcycle_q   <= mcycle_next;
            minstret_q <= minstret_next;
        end
    end
`else
    logic retire_unused;
    assign retire_unused = retire;
`endif

    // The scan print window only matters to simulation models
    logic scan_unused;
    assign scan_unused = scan & (SCAN_CYCLES_MIN <= SCAN_CYCLES_MAX);

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign global_ie = mstatus_mie_q;

endmodule
